// File: rtl/mux_pkg.sv
// mux_pkg - arbitration mode constants and width helper shared by mux_rr_arb.
package mux_pkg;

   localparam int ARB_RR    = 0;
   localparam int ARB_FIXED = 1;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter - one-hot grant over N_CH requests, round-robin or fixed priority; owns the RR pointer.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter  int N_CH = 4,
   localparam int CH_W = (clog2(N_CH) < 1) ? 1 : clog2(N_CH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] req_i,
   input  logic            advance_i,
   input  logic            mode_i,
   output logic [N_CH-1:0] grant_o,
   output logic [CH_W-1:0] grant_idx_o
);

   logic [CH_W-1:0] ptr_q;
   logic [CH_W-1:0] ptr_d;
   logic            any_grant;

   // Fixed priority is just a round-robin search pinned to start at channel 0.
   always_comb begin
      int start;
      int j;
      grant_o     = '0;
      grant_idx_o = '0;
      any_grant   = 1'b0;
      j           = 0;
      start       = mode_i ? 0 : int'(ptr_q);
      for (int k = 0; k < N_CH; k++) begin
         j = (start + k) % N_CH;
         if (!any_grant && req_i[j]) begin
            any_grant   = 1'b1;
            grant_o[j]  = 1'b1;
            grant_idx_o = CH_W'(j);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance_i && any_grant && !mode_i)
         ptr_d = (grant_idx_o == CH_W'(N_CH - 1)) ? '0 : grant_idx_o + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/mux_rr_arb.sv
// mux_rr_arb - arbitrated N-channel merge into a single registered valid/ready output.
module mux_rr_arb
   import mux_pkg::*;
#(
   parameter  int N_CH     = 4,
   parameter  int DATA_W   = 8,
   parameter  int ARB_MODE = 0,
   localparam int CH_W     = (clog2(N_CH) < 1) ? 1 : clog2(N_CH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_CH-1:0]        in_valid,
   input  logic [N_CH*DATA_W-1:0] in_data,
   output logic [N_CH-1:0]        in_ready,
   output logic                   out_valid,
   output logic [DATA_W-1:0]      out_data,
   output logic [CH_W-1:0]        out_ch,
   input  logic                   out_ready
);

   logic [N_CH-1:0]   grant;
   logic [CH_W-1:0]   grant_idx;
   logic              load_en;
   logic              transfer;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [CH_W-1:0]   out_ch_q, out_ch_d;

   assign load_en  = !out_valid_q || out_ready;
   // Gating on rst_n keeps upstream from seeing an accept while the register is held clear.
   assign in_ready = (load_en && rst_n) ? grant : '0;
   assign transfer = |in_ready;

   rr_arbiter #(.N_CH(N_CH)) u_arb (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_i      (in_valid),
      .advance_i  (transfer),
      .mode_i     (ARB_MODE == ARB_FIXED),
      .grant_o    (grant),
      .grant_idx_o(grant_idx)
   );

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      if (load_en) begin
         out_valid_d = transfer;
         if (transfer) begin
            out_data_d = in_data[grant_idx*DATA_W +: DATA_W];
            out_ch_d   = grant_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_rr_arb.sv
// tb_mux_rr_arb - directed vectors for round-robin and fixed-priority instances of mux_rr_arb.
module tb_mux_rr_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  in_valid, in_valid_b;
   logic [31:0] in_data;
   logic [3:0]  in_ready, in_ready_b;
   logic        out_valid, out_valid_b;
   logic [7:0]  out_data, out_data_b;
   logic [1:0]  out_ch, out_ch_b;
   logic        out_ready, out_ready_b;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   mux_rr_arb #(.N_CH(4), .DATA_W(8), .ARB_MODE(0)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
      .out_ch(out_ch), .out_ready(out_ready)
   );

   mux_rr_arb #(.N_CH(4), .DATA_W(8), .ARB_MODE(1)) dut_fix (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_data(in_data),
      .in_ready(in_ready_b), .out_valid(out_valid_b), .out_data(out_data_b),
      .out_ch(out_ch_b), .out_ready(out_ready_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n       = 1'b0;
      in_valid    = 4'b1111;
      in_valid_b  = 4'b0000;
      in_data     = {8'h13, 8'h12, 8'h11, 8'h10};
      out_ready   = 1'b1;
      out_ready_b = 1'b1;
      step();
      step();
      check("rst_in_ready", 32'(in_ready), 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      in_valid = 4'b0000;
      rst_n    = 1'b1;
      step();

      // single word on channel 0
      in_data[7:0] = 8'hA5;
      in_valid     = 4'b0001;
      #1;
      check("single_in_ready", 32'(in_ready), 32'h1);
      step();
      in_valid = 4'b0000;
      check("single_valid", 32'(out_valid), 32'h1);
      check("single_data", 32'(out_data), 32'hA5);
      check("single_ch", 32'(out_ch), 32'h0);

      // reset while FULL drops the word immediately
      out_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 32'(out_valid), 32'h0);
      check("midrst_data", 32'(out_data), 32'h0);
      check("midrst_ch", 32'(out_ch), 32'h0);
      step();
      rst_n        = 1'b1;
      in_data[7:0] = 8'h10;
      out_ready    = 1'b1;
      step();

      // round robin over all channels, one word per cycle
      in_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("rr_in_ready", 32'(in_ready), 32'(1 << (k % 4)));
         step();
         check("rr_valid", 32'(out_valid), 32'h1);
         check("rr_ch", 32'(out_ch), 32'(k % 4));
         check("rr_data", 32'(out_data), 32'(8'h10 + (k % 4)));
      end

      // backpressure: hold 8'h11 on channel 1
      in_valid = 4'b0010;
      #1;
      check("bp_load_ready", 32'(in_ready), 32'h2);
      step();
      check("bp_data", 32'(out_data), 32'h11);
      out_ready = 1'b0;
      in_valid  = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp_in_ready", 32'(in_ready), 32'h0);
         step();
         check("bp_hold_data", 32'(out_data), 32'h11);
         check("bp_hold_ch", 32'(out_ch), 32'h1);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", 32'(in_ready), 32'h4);
      step();
      check("bp_next_data", 32'(out_data), 32'h12);
      check("bp_next_ch", 32'(out_ch), 32'h2);

      // wrap: grant ch3, then 1001 -> ch0, ch3
      in_valid = 4'b1000;
      step();
      check("wrap_ch3", 32'(out_ch), 32'h3);
      in_valid = 4'b1001;
      step();
      check("wrap_ch0", 32'(out_ch), 32'h0);
      check("wrap_ch0_data", 32'(out_data), 32'h10);
      step();
      check("wrap_ch3_again", 32'(out_ch), 32'h3);
      check("wrap_ch3_data", 32'(out_data), 32'h13);
      in_valid = 4'b0000;
      step();
      check("drain_empty", 32'(out_valid), 32'h0);

      // fixed priority instance: lowest index always wins
      in_valid_b = 4'b0110;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("fix_in_ready", 32'(in_ready_b), 32'h2);
         step();
         check("fix_ch", 32'(out_ch_b), 32'h1);
         check("fix_data", 32'(out_data_b), 32'h11);
      end
      in_valid_b = 4'b0000;
      step();
      check("fix_drain", 32'(out_valid_b), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
